// File: rtl/skid_buffer.sv
// Two-entry elastic stage between the instruction FIFO and decode; SKID_STALL_CTR_EN adds stall_ctr.
// Latency: 1 cycle from in_fire to out_data when EMPTY, or when BUSY with a same-cycle out_fire.
// Backpressure: in_ready depends on registered state only (low when FULL), so decode's ready never reaches the FIFO combinationally.
module skid_buffer #(
  parameter int WIDTH = 32
`ifdef SKID_STALL_CTR_EN
  , parameter int STALL_CTR_WIDTH = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
`ifdef SKID_STALL_CTR_EN
  , output logic [STALL_CTR_WIDTH-1:0] stall_ctr
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             in_fire, out_fire;
  logic             main_ld_in, main_ld_skid, skid_ld;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign out_data = main_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state <= state_nxt;
      if (main_ld_in)
        main_q <= in_data;
      else if (main_ld_skid)
        main_q <= skid_q;
      if (skid_ld)
        skid_q <= in_data;
    end
  end

  always_comb begin
    state_nxt    = state;
    main_ld_in   = 1'b0;
    main_ld_skid = 1'b0;
    skid_ld      = 1'b0;
    in_ready     = 1'b1;
    out_valid    = 1'b0;
    count        = 2'd0;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          state_nxt  = BUSY;
          main_ld_in = 1'b1;
        end
      end
      BUSY: begin
        out_valid = 1'b1;
        count     = 2'd1;
        if (in_fire && !out_fire) begin
          state_nxt = FULL;
          skid_ld   = 1'b1;
        end else if (!in_fire && out_fire) begin
          state_nxt = EMPTY;
        end else if (in_fire && out_fire) begin
          main_ld_in = 1'b1;
        end
      end
      FULL: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        count     = 2'd2;
        if (out_fire) begin
          state_nxt    = BUSY;
          main_ld_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // Flush discards everything, including a payload accepted this same cycle.
    if (flush) begin
      state_nxt    = EMPTY;
      main_ld_in   = 1'b0;
      main_ld_skid = 1'b0;
      skid_ld      = 1'b0;
    end
  end

`ifdef SKID_STALL_CTR_EN
  // Saturating count of cycles where decode holds off a valid entry; survives flush.
  always_ff @(posedge clk) begin
    if (rst)
      stall_ctr <= '0;
    else if (out_valid && !out_ready && (stall_ctr != {STALL_CTR_WIDTH{1'b1}}))
      stall_ctr <= stall_ctr + 1'b1;
  end
`else
  // No stall instrumentation in this build.
`endif

endmodule

// File: tb/tb_skid_buffer.sv
// Self-checking bench for skid_buffer: directed scenarios plus randomized traffic against a queue model.
module tb_skid_buffer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_data, out_data;
  logic [1:0]   count;
`ifdef SKID_STALL_CTR_EN
  logic [3:0]   stall_ctr;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  skid_buffer #(
    .WIDTH(W)
`ifdef SKID_STALL_CTR_EN
    , .STALL_CTR_WIDTH(4)
`endif
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
`ifdef SKID_STALL_CTR_EN
    , .stall_ctr(stall_ctr)
`endif
  );

  // Apply inputs for one clock, then settle just after the edge.
  task automatic drive(input logic iv, input logic [W-1:0] id, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++;
    if (count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++;
    if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    drive(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (count !== 2'd0) begin errors++; $display("FAIL reset_idle_count: got %0d want 0", count); end
  endtask

  task automatic test_streaming;
    logic [W-1:0] vals [3];
    vals = '{32'h11, 32'h22, 32'h33};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, vals[i], 1'b1, 1'b0);
      checks++;
      if (out_data !== vals[i] || count !== 2'd1 || in_ready !== 1'b1)
        begin errors++; $display("FAIL stream_%0d: got data=%h count=%0d in_ready=%b want data=%h count=1 in_ready=1", i, out_data, count, in_ready, vals[i]); end
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (count !== 2'd0) begin errors++; $display("FAIL stream_drain: got count=%0d want 0", count); end
  endtask

  task automatic test_backpressure;
    drive(1'b1, 32'hA1, 1'b0, 1'b0);
    drive(1'b1, 32'hA2, 1'b0, 1'b0);
    checks++;
    if (count !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hA1)
      begin errors++; $display("FAIL bp_full: got count=%0d in_ready=%b data=%h want 2 0 a1", count, in_ready, out_data); end
    drive(1'b1, 32'hA3, 1'b0, 1'b0);
    checks++;
    if (count !== 2'd2 || out_data !== 32'hA1)
      begin errors++; $display("FAIL bp_hold: got count=%0d data=%h want 2 a1", count, out_data); end
    drive(1'b1, 32'hA3, 1'b1, 1'b0);
    checks++;
    if (count !== 2'd1 || out_data !== 32'hA2 || in_ready !== 1'b1)
      begin errors++; $display("FAIL bp_second: got count=%0d data=%h in_ready=%b want 1 a2 1", count, out_data, in_ready); end
    drive(1'b1, 32'hA3, 1'b1, 1'b0);
    checks++;
    if (count !== 2'd1 || out_data !== 32'hA3)
      begin errors++; $display("FAIL bp_third: got count=%0d data=%h want 1 a3", count, out_data); end
    drive(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (count !== 2'd0 || out_valid !== 1'b0)
      begin errors++; $display("FAIL bp_drain: got count=%0d out_valid=%b want 0 0 (duplicate?)", count, out_valid); end
  endtask

  task automatic test_flush;
    drive(1'b1, 32'hB1, 1'b0, 1'b0);
    drive(1'b1, 32'hB2, 1'b0, 1'b0);
    drive(1'b1, 32'hB3, 1'b0, 1'b1);
    checks++;
    if (count !== 2'd0 || out_valid !== 1'b0)
      begin errors++; $display("FAIL flush_full: got count=%0d out_valid=%b want 0 0", count, out_valid); end
    drive(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (count !== 2'd0 || out_valid !== 1'b0)
      begin errors++; $display("FAIL flush_no_b3: got count=%0d out_valid=%b want 0 0", count, out_valid); end
    // Flush from BUSY with a real in_fire: the accepted payload must vanish.
    drive(1'b1, 32'hB4, 1'b0, 1'b0);
    drive(1'b1, 32'hB5, 1'b0, 1'b1);
    checks++;
    if (count !== 2'd0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL flush_busy: got count=%0d in_ready=%b want 0 1", count, in_ready); end
    drive(1'b1, 32'hB6, 1'b1, 1'b0);
    checks++;
    if (count !== 2'd1 || out_data !== 32'hB6)
      begin errors++; $display("FAIL flush_refill: got count=%0d data=%h want 1 b6", count, out_data); end
    drive(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_simultaneous;
    drive(1'b1, 32'hC1, 1'b0, 1'b0);
    checks++;
    if (count !== 2'd1 || out_data !== 32'hC1)
      begin errors++; $display("FAIL simul_load: got count=%0d data=%h want 1 c1", count, out_data); end
    drive(1'b1, 32'hC2, 1'b1, 1'b0);
    checks++;
    if (count !== 2'd1 || out_data !== 32'hC2)
      begin errors++; $display("FAIL simul_swap: got count=%0d data=%h want 1 c2", count, out_data); end
    drive(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (count !== 2'd0) begin errors++; $display("FAIL simul_drain: got count=%0d want 0", count); end
  endtask

  task automatic test_random;
    logic [W-1:0] q[$];
    logic         iv, ordy, fl, rs, acc;
    logic [W-1:0] d;
    int           sc;
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    sc = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 19) == 0);
      rs   = ($urandom_range(0, 99) == 0);
      d    = $urandom;
      acc  = (q.size() < 2) && iv;
      if (rs) begin
        q.delete();
        sc = 0;
      end else begin
        if (q.size() > 0 && !ordy && sc < 15) sc++;
        if (q.size() > 0 && ordy) void'(q.pop_front());
        if (fl) q.delete();
        else if (acc) q.push_back(d);
      end
      rst = rs;
      drive(iv, d, ordy, fl);
      rst = 1'b0;
      checks++;
      if (count !== 2'(q.size()) || out_valid !== (q.size() != 0) || in_ready !== (q.size() < 2))
        begin errors++; $display("FAIL rand_state@%0d: got count=%0d out_valid=%b in_ready=%b want count=%0d", cyc, count, out_valid, in_ready, q.size()); end
      if (q.size() > 0) begin
        checks++;
        if (out_data !== q[0])
          begin errors++; $display("FAIL rand_data@%0d: got %h want %h", cyc, out_data, q[0]); end
      end
`ifdef SKID_STALL_CTR_EN
      checks++;
      if (stall_ctr !== 4'(sc))
        begin errors++; $display("FAIL rand_stall@%0d: got %0d want %0d", cyc, stall_ctr, sc); end
`endif
    end
    drive(1'b0, '0, 1'b1, 1'b1);
  endtask

`ifdef SKID_STALL_CTR_EN
  task automatic test_stall_ctr;
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    drive(1'b1, 32'hD1, 1'b0, 1'b0);
    checks++;
    if (stall_ctr !== 4'd0) begin errors++; $display("FAIL stall_start: got %0d want 0", stall_ctr); end
    for (int i = 0; i < 20; i++) drive(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (stall_ctr !== 4'd15) begin errors++; $display("FAIL stall_sat: got %0d want 15", stall_ctr); end
    drive(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (stall_ctr !== 4'd15 || count !== 2'd0)
      begin errors++; $display("FAIL stall_flush: got ctr=%0d count=%0d want 15 0", stall_ctr, count); end
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    checks++;
    if (stall_ctr !== 4'd0) begin errors++; $display("FAIL stall_rst: got %0d want 0", stall_ctr); end
  endtask
`endif

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_simultaneous();
    test_random();
`ifdef SKID_STALL_CTR_EN
    test_stall_ctr();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
